// File: rtl/input_controller_pkg.sv
// Shared types and helpers for the push-button front-end.
// The guarded command macros match command.svh so either may be read first.
`ifndef COMMAND_SVH
`define COMMAND_SVH
`define COMMAND_T logic [1:0]
`define CMD_HIT   2'd0
`define CMD_STAND 2'd1
`define CMD_DEAL  2'd2
`define CMD_CLEAR 2'd3
`endif

package input_controller_pkg;

    localparam int NUM_KEYS = 4;

    // Fixed priority: clear > deal > stand > hit.
    function automatic logic [1:0] selectCmd(input logic [NUM_KEYS-1:0] cand);
        logic [1:0] sel;
        sel = `CMD_HIT;
        if (cand[3]) begin
            sel = `CMD_CLEAR;
        end else if (cand[2]) begin
            sel = `CMD_DEAL;
        end else if (cand[1]) begin
            sel = `CMD_STAND;
        end else begin
            sel = `CMD_HIT;
        end
        return sel;
    endfunction

    // True when more than one candidate is set, i.e. something must be dropped.
    function automatic logic multiHit(input logic [NUM_KEYS-1:0] cand);
        return (cand & (cand - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/command.svh
// Game command encoding shared between the input front-end and the game FSM.
`ifndef COMMAND_SVH
`define COMMAND_SVH
`define COMMAND_T logic [1:0]
`define CMD_HIT   2'd0
`define CMD_STAND 2'd1
`define CMD_DEAL  2'd2
`define CMD_CLEAR 2'd3
`endif

// File: rtl/input_controller_key_debouncer.sv
// One key: synchronizer chain, debounce counter and registered press pulse.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic keyN,
    output logic press,
    output logic held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] syncR;
    logic [CW-1:0]          cntR;
    logic                   stableR;
    logic                   pressR;
    logic                   heldR;
    logic                   syncBitS;

    assign syncBitS = syncR[SYNC_STAGES-1];

    // Plain shift chain; reset to released so no spurious press follows reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            syncR <= {SYNC_STAGES{1'b1}};
        end else begin
            syncR <= {syncR[SYNC_STAGES-2:0], keyN};
        end
    end

    // A change commits only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cntR    <= {CW{1'b0}};
            stableR <= 1'b1;
            pressR  <= 1'b0;
            heldR   <= 1'b0;
        end else if (syncBitS != stableR) begin
            if (cntR == CNT_LAST) begin
                cntR    <= {CW{1'b0}};
                stableR <= syncBitS;
                heldR   <= ~syncBitS;
                pressR  <= ~syncBitS;
            end else begin
                cntR   <= cntR + CW'(1);
                pressR <= 1'b0;
            end
        end else begin
            cntR   <= {CW{1'b0}};
            pressR <= 1'b0;
        end
    end

    assign press = pressR;
    assign held  = heldR;

endmodule

// File: rtl/input_controller.sv
// Push-button front-end: four debounced keys feeding a prioritized,
// single-entry valid/ready command holding register.
module input_controller
    import input_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    input  logic [3:0] cmd_enable,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    output logic [3:0] key_held,
    output logic       cmd_dropped
);

    logic [NUM_KEYS-1:0] pressS;
    logic [NUM_KEYS-1:0] heldS;
    logic [NUM_KEYS-1:0] candS;
    logic                anyCandS;
    logic                validR;
    `COMMAND_T           cmdR;
    logic                droppedR;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : gKey
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) uKey (
            .clk  (clk),
            .rst_n(rst_n),
            .keyN (key_n[i]),
            .press(pressS[i]),
            .held (heldS[i])
        );
    end

    // Disabled keys never become candidates, so they cannot raise a drop.
    always_comb begin
        candS    = {NUM_KEYS{1'b0}};
        anyCandS = 1'b0;
        candS    = pressS & cmd_enable;
        anyCandS = |candS;
    end

    // Holding register: loads when empty or when the current entry is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validR   <= 1'b0;
            cmdR     <= `CMD_HIT;
            droppedR <= 1'b0;
        end else if (anyCandS) begin
            if (!validR || cmd_ready) begin
                validR   <= 1'b1;
                cmdR     <= selectCmd(candS);
                droppedR <= multiHit(candS);
            end else begin
                droppedR <= 1'b1;
            end
        end else begin
            droppedR <= 1'b0;
            if (validR && cmd_ready) begin
                validR <= 1'b0;
            end else begin
                validR <= validR;
            end
        end
    end

    assign cmd_valid   = validR;
    assign cmd         = cmdR;
    assign cmd_dropped = droppedR;
    assign key_held    = heldS;

endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_input_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_n;
    logic [3:0] cmd_enable;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [3:0] key_held;
    logic       cmd_dropped;

    int checks;
    int errors;

    input_controller #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .cmd_enable (cmd_enable),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .key_held   (key_held),
        .cmd_dropped(cmd_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOut(input string tag, input logic v, input logic [1:0] c,
                            input logic [3:0] h, input logic d);
        check({tag, ".valid"}, {3'b000, cmd_valid}, {3'b000, v});
        check({tag, ".cmd"}, {2'b00, cmd}, {2'b00, c});
        check({tag, ".held"}, key_held, h);
        check({tag, ".dropped"}, {3'b000, cmd_dropped}, {3'b000, d});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        key_n      = 4'b1111;
        cmd_enable = 4'b1111;
        cmd_ready  = 1'b0;
        step(3);
        checkOut("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Single hit press: valid exactly 7 cycles after the raw edge.
        key_n = 4'b1110;
        step(6);
        checkOut("hit_c6", 1'b0, 2'd0, 4'b0001, 1'b0);
        step(1);
        checkOut("hit_c7", 1'b1, 2'd0, 4'b0001, 1'b0);
        step(3);
        checkOut("hit_hold", 1'b1, 2'd0, 4'b0001, 1'b0);
        cmd_ready = 1'b1;
        step(1);
        checkOut("hit_taken", 1'b0, 2'd0, 4'b0001, 1'b0);
        cmd_ready = 1'b0;
        key_n = 4'b1111;
        step(8);
        checkOut("hit_release", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Three-cycle glitch on stand is filtered out.
        key_n = 4'b1101;
        step(3);
        key_n = 4'b1111;
        step(1);
        checkOut("glitch_mid", 1'b0, 2'd0, 4'b0000, 1'b0);
        step(10);
        checkOut("glitch_end", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Hit and deal together: deal wins, hit dropped.
        key_n = 4'b1010;
        step(6);
        checkOut("multi_c6", 1'b0, 2'd0, 4'b0101, 1'b0);
        step(1);
        checkOut("multi_c7", 1'b1, 2'd2, 4'b0101, 1'b1);
        step(1);
        checkOut("multi_c8", 1'b1, 2'd2, 4'b0101, 1'b0);

        // Stand while deal pending and not ready: stand dropped.
        key_n = 4'b1000;
        step(7);
        checkOut("busy_drop", 1'b1, 2'd2, 4'b0111, 1'b1);
        step(1);
        checkOut("busy_after", 1'b1, 2'd2, 4'b0111, 1'b0);
        key_n = 4'b1010;
        step(8);
        checkOut("stand_rel", 1'b1, 2'd2, 4'b0101, 1'b0);

        // Stand commits in the same cycle deal is accepted: no bubble.
        key_n = 4'b1000;
        step(6);
        checkOut("b2b_pre", 1'b1, 2'd2, 4'b0111, 1'b0);
        cmd_ready = 1'b1;
        step(1);
        checkOut("b2b_load", 1'b1, 2'd1, 4'b0111, 1'b0);
        step(1);
        checkOut("b2b_drain", 1'b0, 2'd1, 4'b0111, 1'b0);
        cmd_ready = 1'b0;
        key_n = 4'b1111;
        step(8);
        checkOut("all_rel", 1'b0, 2'd1, 4'b0000, 1'b0);

        // Only deal enabled: hit ignored silently, deal accepted.
        cmd_enable = 4'b0100;
        key_n = 4'b1110;
        step(7);
        checkOut("dis_hit", 1'b0, 2'd1, 4'b0001, 1'b0);
        key_n = 4'b1010;
        step(7);
        checkOut("en_deal", 1'b1, 2'd2, 4'b0101, 1'b0);

        // Reset while deal pending and keys still held.
        rst_n = 1'b0;
        step(1);
        checkOut("mid_reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        rst_n = 1'b1;
        step(6);
        checkOut("post_rst_c6", 1'b0, 2'd0, 4'b0101, 1'b0);
        step(1);
        checkOut("post_rst_c7", 1'b1, 2'd2, 4'b0101, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
